// File: rtl/mul_shift_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_shift_add_seq
// Brief    : Iterative unsigned shift-and-add multiplier, one N+1-bit add per
//            clock, 2N-bit product with start/busy/done handshake.
//            Optional macro MUL_ZERO_BYPASS_EN: zero operands finish in 1 cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mul_shift_add_seq #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic [2*N-1:0]  r_product;
    logic [N-1:0]    r_a;
    logic [2*N-1:0]  r_p;
    logic [CW-1:0]   r_cnt;

    logic [N:0]      w_sum;
    logic [2*N-1:0]  w_p_next;
    logic            w_last;

    // The add keeps its carry; it becomes the new MSB after the right shift.
    always_comb begin
        w_sum    = {1'b0, r_p[2*N-1:N]} + (r_p[0] ? {1'b0, r_a} : {(N+1){1'b0}});
        w_p_next = {w_sum, r_p[N-1:1]};
    end

    assign w_last = (r_cnt == C_LAST);

`ifdef MUL_ZERO_BYPASS_EN
    logic w_zero;
    assign w_zero = (multiplicand == '0) || (multiplier == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
            r_a       <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a    <= multiplicand;
                        r_p    <= {{N{1'b0}}, multiplier};
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
                        if (w_zero) begin
                            r_product <= '0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state   <= S_RUN;
                        end
`else
                        r_state <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_product <= w_p_next;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mul_shift_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_shift_add_seq
// Brief    : Directed self-checking bench with a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_shift_add_seq;

    localparam int N = 32;
`ifdef MUL_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = N + 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [2*N-1:0] product;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int cyc      = 0;

    // Model: cycles of busy remaining, the pending result, the visible product.
    int             m_left = 0;
    logic [2*N-1:0] m_pend = '0;
    logic [2*N-1:0] m_prod = '0;

    mul_shift_add_seq #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_left = 0;
            m_prod = '0;
        end else if (m_left == 0) begin
            if (start) begin
                m_pend = {32'b0, a} * {32'b0, b};
                m_left = N + 1;
`ifdef MUL_ZERO_BYPASS_EN
                if (a == 0 || b == 0) begin
                    m_left = 1;
                    m_prod = '0;
                end
`endif
            end
        end else begin
            m_left--;
            if (m_left == 1) m_prod = m_pend;
        end
        #1;
        if (done === 1'b1) done_cnt++;
        chk("cyc_busy", {63'b0, busy}, {63'b0, (m_left > 0)});
        chk("cyc_done", {63'b0, done}, {63'b0, (m_left == 1)});
        chk("cyc_product", product, m_prod);
    end

    task automatic wait_idle();
        int guard = 0;
        while (busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("wait_idle_timeout", 64'(guard), 64'd0);
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) chk({name, "_timeout"}, 64'(lat), 64'd0);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv,
                          input logic [63:0] exp_p, input int exp_lat, input string name);
        int lat;
        wait_idle();
        start = 1'b1; a = ta; b = tbv;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        wait_done(name, lat);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_prod"}, product, exp_p);
    endtask

    initial begin
        int lat;
        int dc0;
        int prev_cyc;
        logic [63:0] b2b_exp [4];
        b2b_exp = '{64'd2, 64'd6, 64'd12, 64'd20};

        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_product", product, 64'd0);
        rst = 1'b0;

        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 33, "basic");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, "carry_max");
        run_op(32'h8000_0000, 32'h0000_0003, 64'h0000_0001_8000_0000, 33, "carry_msb");

        // Start pulse in the middle of a run must be ignored.
        wait_idle();
        start = 1'b1; a = 32'd7; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", lat);
        chk("ignore_lat", 64'(lat), 64'd23);
        chk("ignore_prod", product, 64'd63);
        dc0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("ignore_no_second_done", 64'(done_cnt), 64'(dc0));
        chk("ignore_prod_held", product, 64'd63);

        // Reset in the middle of a run abandons it.
        wait_idle();
        start = 1'b1; a = 32'd100; b = 32'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);
        chk("midrst_product", product, 64'd0);
        dc0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt), 64'(dc0));
        run_op(32'd6, 32'd7, 64'd42, 33, "after_rst");

        run_op(32'd0, 32'h1234_5678, 64'd0, ZERO_LAT, "zero_a");
        run_op(32'd9, 32'd9, 64'd81, 33, "nonzero");
        run_op(32'h1234_5678, 32'd0, 64'd0, ZERO_LAT, "zero_b");

        // Back-to-back with start held high.
        wait_idle();
        start = 1'b1; a = 32'd1; b = 32'd2;
        prev_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wait_done("b2b", lat);
            if (i > 0) chk("b2b_spacing", 64'(cyc - prev_cyc), 64'd34);
            prev_cyc = cyc;
            chk("b2b_prod", product, b2b_exp[i]);
            a = 32'(i + 2); b = 32'(i + 3);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("b2b_prod_held", product, 64'd20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
